cpu_tmr0: RTL

Timer0 peripheral for the PIC10-compatible core: an 8-bit up-counter with an 8-bit programmable prescaler and an OPTION register, clocked from the instruction-cycle strobe or an external T0CKI pin. It sits beside `cpu_gpio` on the ALU write-back bus and is loaded like any SFR. Its `tmr0_out` drives the `tmr0_reg` input of the SFR read mux, replacing today's constant zero. `option_out` is exported for the controller and for the GPIO pull-up/wake logic.

---
 rtl/cpu_tmr0.sv | 112 +++++++++++
 1 files changed

// File: rtl/cpu_tmr0.sv
// Timer0: 8-bit counter with prescaler and OPTION register for the PIC10-compatible core.
// Define TMR0_EXT_CLK_EN to include the T0CKI external clock path.
`timescale 1ns/1ps
module cpu_tmr0 (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] alu_output,
   input  logic       load_tmr0,
   input  logic       load_option,
   input  logic       inst_cycle,
   input  logic       t0cki,
   output logic [7:0] tmr0_out,
   output logic [7:0] option_out,
   output logic       overflow
);

   logic [7:0] tmr0_q;
   logic [7:0] opt_q;
   logic [7:0] pre_q;
   logic [1:0] inh_q;
   logic       ovf_q;

   logic       tick;
   logic       tick_ok;
   logic       inc;
   logic       psa;
   logic [7:0] ps_mask;

   assign psa = opt_q[3];

`ifdef TMR0_EXT_CLK_EN
   logic sync1_q;
   logic sync2_q;
   logic prev_q;
   logic ext_edge;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= t0cki;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // T0SE selects falling (1) or rising (0) edge of the synchronised pin
   assign ext_edge = opt_q[4] ? (prev_q & ~sync2_q)
                              : (~prev_q & sync2_q);
   assign tick     = opt_q[5] ? ext_edge : inst_cycle;
`else
   logic unused_ext;
   assign unused_ext = ^{t0cki, opt_q[5:4]};
   assign tick       = inst_cycle;
`endif

   // Ticks are swallowed while a TMR0 write is settling
   assign tick_ok = tick & (inh_q == 2'd0);
   assign ps_mask = 8'hFF >> (3'd7 - opt_q[2:0]);
   assign inc     = tick_ok &
                    (psa | ((pre_q & ps_mask) == ps_mask));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         opt_q <= 8'hFF;
      end else if (load_option) begin
         opt_q <= alu_output;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmr0_q <= 8'h00;
         ovf_q  <= 1'b0;
      end else if (load_tmr0) begin
         tmr0_q <= alu_output;
         ovf_q  <= 1'b0;
      end else begin
         ovf_q <= inc & (tmr0_q == 8'hFF);
         if (inc) begin
            tmr0_q <= tmr0_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q <= 8'h00;
      end else if (load_tmr0 || psa) begin
         pre_q <= 8'h00;
      end else if (tick_ok) begin
         pre_q <= pre_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inh_q <= 2'd0;
      end else if (load_tmr0) begin
         inh_q <= 2'd2;
      end else if (inst_cycle && inh_q != 2'd0) begin
         inh_q <= inh_q - 2'd1;
      end
   end

   assign tmr0_out   = tmr0_q;
   assign option_out = opt_q;
   assign overflow   = ovf_q;

endmodule
